// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, load/store width codes, LSU state encoding.
// Also provides the request legality check used at handshake time.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE,
    LSU_READ,
    LSU_MERGE,
    LSU_WRITE,
    LSU_DONE
  } lsu_state_e;

  // Unsigned widths exist only for loads; any other code faults.
  function automatic logic lsu_fault(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] off);
    logic f;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_H:    f = off[0];
      F3_W:    f = |off;
      F3_BU:   f = we;
      F3_HU:   f = we | off[0];
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Pipeline-side request/response bundle of the LSU.
interface lsu_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);
  logic            req_valid;
  logic            req_ready;
  logic            req_we;
  logic [2:0]      req_funct3;
  logic [XLEN-1:0] req_addr;
  logic [XLEN-1:0] req_wdata;
  logic            resp_valid;
  logic [XLEN-1:0] resp_rdata;
  logic            resp_misalign;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_misalign
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_misalign
  );
endinterface

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension and
// store merge of the addressed lane into the previously read word.
module lsu_align
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN = riscv_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = rdata[{offset, 3'b000} +: 8];
    lane_h     = rdata[{offset[1], 4'b0000} +: 16];
    load_data  = rdata;
    store_data = wdata;
    case (funct3)
      F3_B: begin
        load_data                          = {{(XLEN-8){lane_b[7]}}, lane_b};
        store_data                         = rdata;
        store_data[{offset, 3'b000} +: 8]  = wdata[7:0];
      end
      F3_BU: load_data = {{(XLEN-8){1'b0}}, lane_b};
      F3_H: begin
        load_data                              = {{(XLEN-16){lane_h[15]}}, lane_h};
        store_data                             = rdata;
        store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
      end
      F3_HU: load_data = {{(XLEN-16){1'b0}}, lane_h};
      default: ;
    endcase
  end
endmodule

// File: rtl/lsu.sv
// Load/store unit: one request at a time against a single word-wide memory.
// Sub-word stores are read-modify-write because the memory has no byte enables.
module lsu
  import riscv_pkg::*;
#(
  parameter int unsigned XLEN       = riscv_pkg::XLEN,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  lsu_if.slave                  bus,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_rd_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [XLEN-1:0]       mem_wr_data
);
  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            funct3_q, funct3_d;
  logic [ADDR_WIDTH+1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic                  misalign_q, misalign_d;
  logic                  req_ready;
  logic                  handshake;
  logic [XLEN-1:0]       load_data, store_data;
  logic                  unused_addr_hi;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3     (funct3_q),
    .offset     (addr_q[1:0]),
    .rdata      (mem_rd_data),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_comb begin
    req_ready         = rst && (state_q == LSU_IDLE);
    handshake         = bus.req_valid && req_ready;
    bus.req_ready     = req_ready;
    bus.resp_valid    = (state_q == LSU_DONE);
    bus.resp_rdata    = rdata_q;
    bus.resp_misalign = misalign_q;
    mem_rd_addr       = addr_q[ADDR_WIDTH+1:2];
    mem_wr_addr       = addr_q[ADDR_WIDTH+1:2];
    mem_wr_data       = wdata_q;
    unused_addr_hi    = ^bus.req_addr[XLEN-1:ADDR_WIDTH+2];
  end

  // Response registers change only on entry to DONE so they hold between responses.
  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    misalign_d = misalign_q;
    mem_rd_en  = 1'b0;
    mem_wr_en  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (handshake) begin
          we_d     = bus.req_we;
          funct3_d = bus.req_funct3;
          addr_d   = bus.req_addr[ADDR_WIDTH+1:0];
          wdata_d  = bus.req_wdata;
          if (lsu_fault(bus.req_we, bus.req_funct3, bus.req_addr[1:0])) begin
            misalign_d = 1'b1;
            rdata_d    = '0;
            state_d    = LSU_DONE;
          end else if (bus.req_we && (bus.req_funct3 == F3_W)) begin
            state_d = LSU_WRITE;
          end else begin
            state_d = LSU_READ;
          end
        end
      end
      LSU_READ: begin
        mem_rd_en = 1'b1;
        state_d   = LSU_MERGE;
      end
      LSU_MERGE: begin
        if (we_q) begin
          wdata_d = store_data;
          state_d = LSU_WRITE;
        end else begin
          rdata_d    = load_data;
          misalign_d = 1'b0;
          state_d    = LSU_DONE;
        end
      end
      LSU_WRITE: begin
        mem_wr_en  = 1'b1;
        rdata_d    = '0;
        misalign_d = 1'b0;
        state_d    = LSU_DONE;
      end
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= LSU_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      misalign_q <= misalign_d;
    end
  end
endmodule
